eth_rx_fcs_check: RTL and testbench

//  Receive-side companion to the TX CRC32 FCS generator. It accepts the byte stream from the RGMII

---
 rtl/eth_pkg.sv | 35 +++
 rtl/eth_fcs_strip.sv | 81 ++++++++
 rtl/eth_rx_fcs_check.sv | 136 +++++++++++++
 tb/tb_eth_rx_fcs_check.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet types, constants and the byte-wide CRC-32 step used by the
// RX FCS checker and the TX FCS generator.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } state_t;

  typedef struct packed {
    logic len_err;
    logic crc_err;
  } rx_status_t;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;

  // MSB-first register, data fed LSB first (wire order); a good frame leaves
  // CRC32_RESIDUE in the register with no final inversion or bit reversal.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_fcs_strip.sv
// Four-byte delay line plus one-byte hold register: withholds the trailing FCS
// and tags the final payload byte with last/status at frame end.
module eth_fcs_strip
  import eth_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       end_i,
  input  logic       flush_i,
  input  logic [1:0] status_i,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  output logic       m_last_o,
  output logic [1:0] m_user_o,
  output logic       crc_ok_o
);

  logic [7:0] r_sr [4];
  logic [2:0] r_fill;
  logic [7:0] r_hold;
  logic       r_hold_vld;
  rx_status_t w_status;

  assign w_status = rx_status_t'(status_i);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fill     <= '0;
      r_hold_vld <= 1'b0;
      m_data_o   <= '0;
      m_valid_o  <= 1'b0;
      m_last_o   <= 1'b0;
      m_user_o   <= '0;
      crc_ok_o   <= 1'b0;
    end else begin
      m_data_o  <= '0;
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      m_user_o  <= '0;
      crc_ok_o  <= 1'b0;
      if (flush_i) begin
        r_fill     <= '0;
        r_hold_vld <= 1'b0;
      end else if (end_i) begin
        if (r_hold_vld) begin
          m_data_o  <= r_hold;
          m_valid_o <= 1'b1;
          m_last_o  <= 1'b1;
          m_user_o  <= status_i;
          crc_ok_o  <= ~(w_status.len_err | w_status.crc_err);
        end
        r_fill     <= '0;
        r_hold_vld <= 1'b0;
      end else if (push_i) begin
        if (r_hold_vld) begin
          m_data_o  <= r_hold;
          m_valid_o <= 1'b1;
        end
        if (r_fill == 3'd4) r_hold_vld <= 1'b1;
        else                r_fill     <= r_fill + 3'd1;
      end
    end
  end

  // NOTE: pure datapath bytes carry no reset; their validity is tracked by
  // r_fill / r_hold_vld, which are reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !end_i) begin
      r_sr[0] <= data_i;
      r_sr[1] <= r_sr[0];
      r_sr[2] <= r_sr[1];
      r_sr[3] <= r_sr[2];
      if (r_fill == 3'd4) r_hold <= r_sr[3];
    end
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Ethernet RX framer: preamble/SFD detection, FCS strip, CRC-32 residue check
// and length/PHY error reporting on a single-beat payload stream.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_dv_i,
  input  logic       rx_ce_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_er_i,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  output logic       m_last_o,
  output logic [1:0] m_user_o,
  output logic       crc_ok_o
);

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_crc, w_crc_nxt;
  logic             r_phy_err, w_phy_err_nxt;
  logic             r_first;
  logic             w_strobe;
  logic             w_push;
  logic             w_end;
  logic             w_flush;
  rx_status_t       w_status;

  assign w_strobe = rx_dv_i & rx_ce_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_crc     <= CRC32_INIT;
      r_phy_err <= 1'b0;
      r_first   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_crc     <= w_crc_nxt;
      r_phy_err <= w_phy_err_nxt;
      r_first   <= 1'b0;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_crc_nxt     = r_crc;
    w_phy_err_nxt = r_phy_err;
    w_push        = 1'b0;
    w_end         = 1'b0;
    w_flush       = 1'b0;
    w_status      = '0;

    case (r_state)
      IDLE: begin
        // A stream already in flight when reset releases is never picked up.
        if (r_first && rx_dv_i) begin
          w_state_nxt = DROP;
        end else if (w_strobe) begin
          w_state_nxt = (rx_data_i == ETH_PREAMBLE) ? PRE : DROP;
        end
      end

      PRE: begin
        if (!rx_dv_i) begin
          w_state_nxt = IDLE;
        end else if (w_strobe && rx_data_i != ETH_PREAMBLE) begin
          if (rx_data_i == ETH_SFD) begin
            w_state_nxt   = DATA;
            w_cnt_nxt     = '0;
            w_crc_nxt     = CRC32_INIT;
            w_phy_err_nxt = 1'b0;
            w_flush       = 1'b1;
          end else begin
            w_state_nxt = DROP;
          end
        end
      end

      DATA: begin
        if (!rx_dv_i) begin
          w_state_nxt      = IDLE;
          w_end            = 1'b1;
          w_status.len_err = r_phy_err | (r_cnt < LEN_W'(MIN_LEN));
          w_status.crc_err = (r_crc != CRC32_RESIDUE);
        end else if (w_strobe) begin
          if (r_cnt == LEN_W'(MAX_LEN)) begin
            // Oversize: close on the first excess byte; the CRC of a truncated
            // frame carries no information, so only the length error is flagged.
            w_state_nxt      = DROP;
            w_end            = 1'b1;
            w_cnt_nxt        = LEN_W'(MAX_LEN + 1);
            w_status.len_err = 1'b1;
          end else begin
            w_push        = 1'b1;
            w_cnt_nxt     = r_cnt + LEN_W'(1);
            w_crc_nxt     = crc32_d8(r_crc, rx_data_i);
            w_phy_err_nxt = r_phy_err | rx_er_i;
          end
        end
      end

      DROP: begin
        if (!rx_dv_i) w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  eth_fcs_strip u_strip (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .push_i   (w_push),
    .data_i   (rx_data_i),
    .end_i    (w_end),
    .flush_i  (w_flush),
    .status_i (w_status),
    .m_data_o (m_data_o),
    .m_valid_o(m_valid_o),
    .m_last_o (m_last_o),
    .m_user_o (m_user_o),
    .crc_ok_o (crc_ok_o)
  );

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Self-checking bench: two checker instances (default limits and a small
// MIN/MAX variant) fed the same byte stream, compared against a frame-level model.
module tb_eth_rx_fcs_check;

  localparam int A_MIN = 64;
  localparam int A_MAX = 1518;
  localparam int B_MIN = 4;
  localparam int B_MAX = 40;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] user;
    int         cyc;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dv, rx_ce, rx_er;
  logic [7:0] rx_data;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_last, b_last, a_ok, b_ok;
  logic [1:0] a_user, b_user;

  always #5 clk = ~clk;

  eth_rx_fcs_check dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .rx_dv_i(rx_dv), .rx_ce_i(rx_ce),
    .rx_data_i(rx_data), .rx_er_i(rx_er), .m_data_o(a_data), .m_valid_o(a_valid),
    .m_last_o(a_last), .m_user_o(a_user), .crc_ok_o(a_ok)
  );

  eth_rx_fcs_check #(.MIN_LEN(B_MIN), .MAX_LEN(B_MAX), .LEN_W(11)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .rx_dv_i(rx_dv), .rx_ce_i(rx_ce),
    .rx_data_i(rx_data), .rx_er_i(rx_er), .m_data_o(b_data), .m_valid_o(b_valid),
    .m_last_o(b_last), .m_user_o(b_user), .crc_ok_o(b_ok)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t got_a[$], got_b[$], exp_a[$], exp_b[$];
  int    okg_a[$], okg_b[$], oke_a[$], oke_b[$];

  always @(negedge clk) begin
    beat_t b;
    if (a_valid) begin
      b.data = a_data; b.last = a_last;
      b.user = a_last ? a_user : 2'b00; b.cyc = a_last ? cyc : 0;
      got_a.push_back(b);
    end
    if (a_ok) okg_a.push_back(cyc);
  end

  always @(negedge clk) begin
    beat_t b;
    if (b_valid) begin
      b.data = b_data; b.last = b_last;
      b.user = b_last ? b_user : 2'b00; b.cyc = b_last ? cyc : 0;
      got_b.push_back(b);
    end
    if (b_ok) okg_b.push_back(cyc);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] frame_bytes[$];
  int         byte_cyc[$];
  int         drop_cyc;

  // Standard Ethernet CRC-32 (reflected, final inversion) over the first n bytes.
  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frame_bytes[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic append_fcs();
    logic [31:0] c;
    c = crc_of(frame_bytes.size());
    for (int i = 0; i < 4; i++) frame_bytes.push_back(c[8*i +: 8]);
  endtask

  task automatic random_payload(input int n);
    frame_bytes.delete();
    for (int i = 0; i < n; i++) frame_bytes.push_back(8'($urandom));
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic er, input bit tog, output int c);
    @(negedge clk);
    rx_dv = 1'b1; rx_ce = 1'b1; rx_data = b; rx_er = er;
    c = cyc;
    if (tog) begin
      @(negedge clk);
      rx_ce = 1'b0; rx_data = 8'($urandom); rx_er = 1'b0;
    end
  endtask

  task automatic model_frame(input int d, input bit bad, input bit er);
    int          mn, mx, n, n_out, last_c;
    logic        crc_bad;
    logic [1:0]  user;
    beat_t       b;
    mn = (d == 0) ? A_MIN : B_MIN;
    mx = (d == 0) ? A_MAX : B_MAX;
    n  = frame_bytes.size();
    if (bad || n <= 4) return;
    if (n > mx) begin
      n_out  = mx - 4;
      user   = 2'b10;
      last_c = byte_cyc[mx] + 1;
    end else begin
      n_out   = n - 4;
      crc_bad = (crc_of(n - 4) !==
                 {frame_bytes[n-1], frame_bytes[n-2], frame_bytes[n-3], frame_bytes[n-4]});
      user    = {(er || n < mn), crc_bad};
      last_c  = drop_cyc + 1;
    end
    for (int i = 0; i < n_out; i++) begin
      b.data = frame_bytes[i];
      b.last = (i == n_out - 1);
      b.user = b.last ? user : 2'b00;
      b.cyc  = b.last ? last_c : 0;
      if (d == 0) exp_a.push_back(b); else exp_b.push_back(b);
    end
    if (user == 2'b00) begin
      if (d == 0) oke_a.push_back(last_c); else oke_b.push_back(last_c);
    end
  endtask

  task automatic send_frame(input bit bad, input bit tog, input int er_idx, input int gap);
    int c;
    if (bad) begin
      drive_byte(8'h55, 1'b0, tog, c);
      drive_byte(8'h55, 1'b0, tog, c);
      drive_byte(8'hAA, 1'b0, tog, c);
    end else begin
      for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0, tog, c);
    end
    drive_byte(8'hD5, 1'b0, tog, c);
    byte_cyc.delete();
    for (int i = 0; i < frame_bytes.size(); i++) begin
      drive_byte(frame_bytes[i], (i == er_idx), tog, c);
      byte_cyc.push_back(c);
    end
    @(negedge clk);
    rx_dv = 1'b0; rx_ce = 1'b0; rx_er = 1'b0;
    drop_cyc = cyc;
    model_frame(0, bad, (er_idx >= 0 && er_idx < frame_bytes.size()));
    model_frame(1, bad, (er_idx >= 0 && er_idx < frame_bytes.size()));
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic compare_dut(input int d, input string tag);
    beat_t g, e;
    int    ng, ne, f0, og, oe;
    string nm;
    nm = (d == 0) ? "a" : "b";
    ng = (d == 0) ? got_a.size() : got_b.size();
    ne = (d == 0) ? exp_a.size() : exp_b.size();
    check($sformatf("%s/%s/beats", tag, nm), ng, ne);
    f0 = n_fail;
    for (int i = 0; i < ng && i < ne; i++) begin
      if (d == 0) begin g = got_a[i]; e = exp_a[i]; end
      else        begin g = got_b[i]; e = exp_b[i]; end
      check($sformatf("%s/%s/beat%0d", tag, nm, i), {g.data, g.last, g.user}, {e.data, e.last, e.user});
      if (e.last) check($sformatf("%s/%s/last_cyc", tag, nm), g.cyc, e.cyc);
      if (n_fail != f0) break;
    end
    og = (d == 0) ? okg_a.size() : okg_b.size();
    oe = (d == 0) ? oke_a.size() : oke_b.size();
    check($sformatf("%s/%s/crc_ok_cnt", tag, nm), og, oe);
    for (int i = 0; i < og && i < oe; i++) begin
      if (d == 0) check($sformatf("%s/%s/crc_ok_cyc", tag, nm), okg_a[i], oke_a[i]);
      else        check($sformatf("%s/%s/crc_ok_cyc", tag, nm), okg_b[i], oke_b[i]);
    end
  endtask

  task automatic clear_queues();
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    okg_a.delete(); okg_b.delete(); oke_a.delete(); oke_b.delete();
  endtask

  task automatic check_all(input string tag);
    repeat (4) @(negedge clk);
    compare_dut(0, tag);
    compare_dut(1, tag);
    clear_queues();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "/a_out"}, {a_data, a_valid, a_last, a_user, a_ok}, '0);
    check({tag, "/b_out"}, {b_data, b_valid, b_last, b_user, b_ok}, '0);
  endtask

  initial begin
    int c;
    int plist[5];
    rst_n = 1'b0; rx_dv = 1'b0; rx_ce = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // "123456789" with its FCS
    frame_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                    8'h26, 8'h39, 8'hF4, 8'hCB};
    send_frame(1'b0, 1'b0, -1, 3);
    check_all("t1_good");

    frame_bytes[12] = 8'hCA;
    send_frame(1'b0, 1'b0, -1, 3);
    check_all("t2_badfcs");

    frame_bytes.delete();
    for (int i = 0; i < 60; i++) frame_bytes.push_back(8'h00);
    append_fcs();
    send_frame(1'b0, 1'b0, -1, 3);
    check_all("t3_zeros");

    random_payload(20); append_fcs();
    send_frame(1'b1, 1'b0, -1, 1);
    random_payload(30); append_fcs();
    send_frame(1'b0, 1'b0, -1, 3);
    check_all("t4_badpre");

    for (int f = 0; f < 3; f++) begin
      random_payload(8 + 10 * f); append_fcs();
      send_frame(1'b0, 1'b0, -1, 1);
    end
    repeat (2) @(negedge clk);
    check_all("t4_b2b");

    random_payload(70); append_fcs();
    send_frame(1'b0, 1'b0, 30, 3);
    check_all("t5_phyerr");

    // Reset in the middle of a frame, released while dv is still high.
    random_payload(50); append_fcs();
    for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0, 1'b0, c);
    drive_byte(8'hD5, 1'b0, 1'b0, c);
    for (int i = 0; i < 20; i++) drive_byte(frame_bytes[i], 1'b0, 1'b0, c);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("t5_rst");
    clear_queues();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_byte(8'h55, 1'b0, 1'b0, c);
    drive_byte(8'h55, 1'b0, 1'b0, c);
    drive_byte(8'hD5, 1'b0, 1'b0, c);
    for (int i = 0; i < 15; i++) drive_byte(8'($urandom), 1'b0, 1'b0, c);
    @(negedge clk);
    rx_dv = 1'b0; rx_ce = 1'b0;
    repeat (2) @(negedge clk);
    check_all("t5_after_rst");
    random_payload(64); append_fcs();
    send_frame(1'b0, 1'b0, -1, 3);
    check_all("t5_recover");

    frame_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                    8'h26, 8'h39, 8'hF4, 8'hCB};
    send_frame(1'b0, 1'b1, -1, 3);
    check_all("t6_ce_half");

    random_payload(A_MAX + 5);
    send_frame(1'b0, 1'b0, -1, 3);
    check_all("t6_oversize");

    // Tiny frames: 3 and 4 bytes emit nothing; then boundary payload sizes.
    random_payload(3);
    send_frame(1'b0, 1'b0, -1, 3);
    random_payload(4);
    send_frame(1'b0, 1'b0, -1, 3);
    check_all("short_le4");
    plist = '{1, 36, 37, 59, 60};
    for (int i = 0; i < 5; i++) begin
      random_payload(plist[i]); append_fcs();
      send_frame(1'b0, 1'b0, -1, 2);
      check_all($sformatf("bound_p%0d", plist[i]));
    end

    for (int f = 0; f < 6; f++) begin
      int pl, er_idx;
      bit tog;
      pl = $urandom_range(1, 80);
      random_payload(pl); append_fcs();
      if ($urandom_range(0, 2) == 0) frame_bytes[$urandom_range(0, pl + 3)] ^= 8'h10;
      er_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, pl + 3) : -1;
      tog = 1'($urandom_range(0, 1));
      send_frame(1'b0, tog, er_idx, $urandom_range(1, 3));
      check_all($sformatf("rand%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
